// File: rtl/conversor_7seg_binario.sv
// conversor_7seg_binario
//   Turns eight active-low 7-segment digit codes (gfedcba) back into a 32-bit
//   unsigned value. It is the inverse of the binary-to-7-segment converter.
//   A start pulse snapshots the displays. One Horner step (acc*10 + digit) is
//   then done per clock, from display7 (MSD) down to display0 (units).
//
//   Build option: CONVERSOR_BLANK_ZERO_EN
//     Defined   - blank code 1111111 decodes as 0 and is not an error.
//     Undefined - blank code is invalid: it decodes as 0 and sets erro.
//
// Ports
//   clock               rising-edge clock
//   reset               synchronous, active-high
//   inicio              start request, sampled only in IDLE
//   display0..display7  active-low segment codes, display0 = units digit
//   saida   [31:0]      converted value, held until the next completion
//   ocupado             high while a conversion is in progress
//   pronto              one-cycle pulse when saida/erro are updated
//   erro                last conversion saw at least one invalid code

// Single-digit segment decoder. Invalid codes yield 0 with bad=1.
module conversor_7seg_dig (
  input  logic [6:0] seg,
  output logic [3:0] val,
  output logic       bad
);
  always_comb begin
    val = 4'd0;
    bad = 1'b0;
    case (seg)
      7'b1000000: val = 4'd0;
      7'b1111001: val = 4'd1;
      7'b0100100: val = 4'd2;
      7'b0110000: val = 4'd3;
      7'b0011001: val = 4'd4;
      7'b0010010: val = 4'd5;
      7'b0000010: val = 4'd6;
      7'b1111000: val = 4'd7;
      7'b0000000: val = 4'd8;
      7'b0010000: val = 4'd9;
`ifdef CONVERSOR_BLANK_ZERO_EN
      7'b1111111: val = 4'd0;    // suppressed leading zero
`endif
      default:    bad = 1'b1;
    endcase
  end
endmodule

module conversor_7seg_binario (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [6:0]  display0,
  input  logic [6:0]  display1,
  input  logic [6:0]  display2,
  input  logic [6:0]  display3,
  input  logic [6:0]  display4,
  input  logic [6:0]  display5,
  input  logic [6:0]  display6,
  input  logic [6:0]  display7,
  output logic [31:0] saida,
  output logic        ocupado,
  output logic        pronto,
  output logic        erro
);
  localparam int NDIG = 8;

  typedef enum logic {IDLE, CONV} state_t;

  state_t                 state;
  logic [NDIG-1:0][6:0]   snap;
  logic [NDIG-1:0][3:0]   dval;
  logic [NDIG-1:0]        dbad;
  logic [2:0]             idx;
  logic [31:0]            acc;
  logic [31:0]            nxt;
  logic                   errf;

  // Every snapshot digit is decoded in parallel. The step logic only muxes the current index.
  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    conversor_7seg_dig u_dig (
      .seg (snap[g]),
      .val (dval[g]),
      .bad (dbad[g])
    );
  end

  // acc*10 as shift-add. The maximum 99,999,999 fits well inside 32 bits.
  assign nxt = (acc << 3) + (acc << 1) + {28'd0, dval[idx]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      snap    <= '0;
      acc     <= '0;
      idx     <= '0;
      errf    <= 1'b0;
      saida   <= '0;
      ocupado <= 1'b0;
      pronto  <= 1'b0;
      erro    <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (state)
        IDLE: begin
          if (inicio) begin
            snap    <= {display7, display6, display5, display4,
                        display3, display2, display1, display0};
            acc     <= '0;
            errf    <= 1'b0;
            idx     <= 3'd7;
            ocupado <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          if (idx != 3'd0) begin
            acc  <= nxt;
            errf <= errf | dbad[idx];
            idx  <= idx - 3'd1;
          end else begin
            // The last step writes straight to the outputs, so results change only here.
            saida   <= nxt;
            erro    <= errf | dbad[0];
            pronto  <= 1'b1;
            ocupado <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_conversor_7seg_binario.sv
module tb_conversor_7seg_binario;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SA = 7'b0001000, SB = 7'b1111111;

  logic             clock = 1'b0;
  logic             reset;
  logic             inicio;
  logic [7:0][6:0]  disp;
  logic [31:0]      saida;
  logic             ocupado, pronto, erro;

  int errors = 0;
  int checks = 0;
  logic [31:0] prev_saida;
  logic        prev_erro;

  typedef struct {
    logic [7:0][6:0] d;
    logic [31:0]     val;
    logic            err;
  } vec_t;
  vec_t tbl[8];

  always #5 clock = ~clock;

  conversor_7seg_binario dut (
    .clock    (clock),
    .reset    (reset),
    .inicio   (inicio),
    .display0 (disp[0]),
    .display1 (disp[1]),
    .display2 (disp[2]),
    .display3 (disp[3]),
    .display4 (disp[4]),
    .display5 (disp[5]),
    .display6 (disp[6]),
    .display7 (disp[7]),
    .saida    (saida),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .erro     (erro)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
    end
  endtask

  // Called on a negedge. It starts a conversion and checks the whole transaction.
  task automatic conv(input logic [7:0][6:0] d, input logic [31:0] ev, input logic ee);
    disp = d;
    inicio = 1'b1;
    @(negedge clock);            // after E0
    inicio = 1'b0;
    chk("saida_hold_at_start", saida, prev_saida);
    chk("erro_hold_at_start", {31'd0, erro}, {31'd0, prev_erro});
    for (int i = 0; i < 8; i++) begin
      chk("ocupado_busy", {31'd0, ocupado}, 32'd1);
      chk("pronto_low_busy", {31'd0, pronto}, 32'd0);
      @(negedge clock);
    end
    // after E8
    chk("pronto_pulse", {31'd0, pronto}, 32'd1);
    chk("ocupado_done", {31'd0, ocupado}, 32'd0);
    chk("saida", saida, ev);
    chk("erro", {31'd0, erro}, {31'd0, ee});
    prev_saida = ev;
    prev_erro  = ee;
    @(negedge clock);            // after E9
    chk("pronto_drop", {31'd0, pronto}, 32'd0);
    chk("saida_stable", saida, ev);
  endtask

  initial begin
    tbl[0] = '{d: {S1,S2,S3,S4,S5,S6,S7,S8}, val: 32'd12345678, err: 1'b0};
    tbl[1] = '{d: {S0,S0,S0,S0,S0,S0,S0,S0}, val: 32'd0,        err: 1'b0};
    tbl[2] = '{d: {S9,S9,S9,S9,S9,S9,S9,S9}, val: 32'd99999999, err: 1'b0};
    tbl[3] = '{d: {S9,S9,S9,S9,SA,S9,S9,S9}, val: 32'd99990999, err: 1'b1};
    tbl[4] = '{d: {S1,S2,S3,S4,S5,S6,S7,S8}, val: 32'd12345678, err: 1'b0};
`ifdef CONVERSOR_BLANK_ZERO_EN
    tbl[5] = '{d: {SB,SB,S0,S0,S0,S0,S4,S2}, val: 32'd42,       err: 1'b0};
`else
    tbl[5] = '{d: {SB,SB,S0,S0,S0,S0,S4,S2}, val: 32'd42,       err: 1'b1};
`endif
    tbl[6] = '{d: {S0,S0,S0,S0,S0,S0,S0,S1}, val: 32'd1,        err: 1'b0};
    tbl[7] = '{d: {S8,S7,S6,S5,S4,S3,S2,S1}, val: 32'd87654321, err: 1'b0};

    reset  = 1'b1;
    inicio = 1'b0;
    disp   = {S0,S0,S0,S0,S0,S0,S0,S0};
    repeat (3) @(negedge clock);
    chk("reset_saida", saida, 32'd0);
    chk("reset_ocupado", {31'd0, ocupado}, 32'd0);
    chk("reset_pronto", {31'd0, pronto}, 32'd0);
    chk("reset_erro", {31'd0, erro}, 32'd0);
    reset = 1'b0;
    prev_saida = 32'd0;
    prev_erro  = 1'b0;
    @(negedge clock);
    chk("idle_no_start", {31'd0, ocupado}, 32'd0);

    for (int v = 0; v < 8; v++) conv(tbl[v].d, tbl[v].val, tbl[v].err);

    // Snapshot: the displays change and inicio pulses mid-conversion.
    disp = {S2,S4,S6,S8,S1,S3,S5,S7};
    inicio = 1'b1;
    @(negedge clock);            // after E0
    inicio = 1'b0;
    @(negedge clock);            // after E1
    @(negedge clock);            // after E2
    disp = {S9,S9,S9,S9,S9,S9,S9,S9};
    inicio = 1'b1;
    @(negedge clock);            // after E3
    inicio = 1'b0;
    repeat (5) @(negedge clock); // after E8
    chk("snap_pronto", {31'd0, pronto}, 32'd1);
    chk("snap_saida", saida, 32'd24681357);
    chk("snap_erro", {31'd0, erro}, 32'd0);
    @(negedge clock);            // after E9
    chk("snap_no_second_conv", {31'd0, ocupado}, 32'd0);
    chk("snap_pronto_drop", {31'd0, pronto}, 32'd0);
    prev_saida = 32'd24681357;
    prev_erro  = 1'b0;

    // Reset during CONV, after an erroring result so that erro=1 beforehand.
    conv(tbl[3].d, tbl[3].val, tbl[3].err);
    inicio = 1'b1;
    @(negedge clock);            // after E0
    inicio = 1'b0;
    repeat (3) @(negedge clock); // after E3
    reset = 1'b1;
    @(negedge clock);            // after E4, under reset
    chk("abort_saida", saida, 32'd0);
    chk("abort_ocupado", {31'd0, ocupado}, 32'd0);
    chk("abort_pronto", {31'd0, pronto}, 32'd0);
    chk("abort_erro", {31'd0, erro}, 32'd0);
    reset = 1'b0;
    repeat (9) begin
      @(negedge clock);
      chk("abort_no_pronto", {31'd0, pronto}, 32'd0);
    end
    prev_saida = 32'd0;
    prev_erro  = 1'b0;
    conv(tbl[0].d, tbl[0].val, tbl[0].err);

    // inicio held high gives back-to-back conversions every 9 cycles.
    disp = tbl[7].d;
    inicio = 1'b1;
    @(negedge clock);            // after E0
    repeat (8) @(negedge clock); // after E8
    chk("tput_pronto", {31'd0, pronto}, 32'd1);
    chk("tput_saida", saida, 32'd87654321);
    @(negedge clock);            // after E9: restarted
    chk("tput_restart_ocupado", {31'd0, ocupado}, 32'd1);
    chk("tput_restart_pronto", {31'd0, pronto}, 32'd0);
    inicio = 1'b0;
    repeat (8) @(negedge clock); // after E17
    chk("tput_second_pronto", {31'd0, pronto}, 32'd1);
    chk("tput_second_saida", saida, 32'd87654321);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
